// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ---------------------------------------------------------------------------
// Pipeline register between register-read (decode) and execute for the
// 5-stage 64-bit CPU. It captures both register-file read ports, the decoded
// control byte and the sign-extended immediate.
//
// The register file only updates at the clock edge, so a write-back that is
// in flight during the same cycle is bypassed into the captured operands.
// While stalled, the held operands keep listening to write-back so that a
// result landing mid-stall is not lost. Flush inserts a bubble and wins
// over stall.
//
// Ports:
//   clk, reset                       rising-edge clock, async active-high reset
//   ReadData1/2, ReadRegister1/2     register file read ports and their indices
//   id_Rd, id_valid, id_ctrl, id_imm decoded destination, valid, control, imm
//   stall, flush                     hold current EX contents / insert bubble
//   wb_RegWrite, wb_WriteRegister,
//   wb_WriteData                     write-back port (same as register file)
//   ex_A, ex_B                       bypassed operands
//   ex_Rn, ex_Rm, ex_Rd              latched source/destination indices
//   ex_ctrl, ex_imm, ex_valid        latched control, immediate, valid
//   bubble_count                     (only with BUBBLE_CNT_EN) saturating count
//                                    of edges that loaded a bubble
//
// Optional feature macro: BUBBLE_CNT_EN
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int regSize = 64,
   parameter int regAddr = 5,
   parameter int zeroReg = 31
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [regSize-1:0] ReadData1,
   input  logic [regSize-1:0] ReadData2,
   input  logic [regAddr-1:0] ReadRegister1,
   input  logic [regAddr-1:0] ReadRegister2,
   input  logic [regAddr-1:0] id_Rd,
   input  logic               id_valid,
   input  logic [7:0]         id_ctrl,
   input  logic [regSize-1:0] id_imm,
   input  logic               stall,
   input  logic               flush,
   input  logic               wb_RegWrite,
   input  logic [regAddr-1:0] wb_WriteRegister,
   input  logic [regSize-1:0] wb_WriteData,
   output logic [regSize-1:0] ex_A,
   output logic [regSize-1:0] ex_B,
   output logic [regAddr-1:0] ex_Rn,
   output logic [regAddr-1:0] ex_Rm,
   output logic [regAddr-1:0] ex_Rd,
   output logic [7:0]         ex_ctrl,
   output logic [regSize-1:0] ex_imm,
   output logic               ex_valid
`ifdef BUBBLE_CNT_EN
   ,
   output logic [31:0]        bubble_count
`endif
);

   localparam logic [regAddr-1:0] zeroIdx = regAddr'(zeroReg);

   typedef enum logic {
      RUN,
      HOLD
   } stageState_t;

   stageState_t state;

   logic [regSize-1:0] nextA;
   logic [regSize-1:0] nextB;

   // Write-back bypass for one operand. XZR always reads as zero and can
   // never be the target of a bypass.
   function automatic logic [regSize-1:0] byp(input logic [regAddr-1:0] idx,
                                              input logic [regSize-1:0] rdata);
      logic [regSize-1:0] result;
      result = rdata;
      if (idx == zeroIdx) begin
         result = '0;
      end else if (wb_RegWrite && (wb_WriteRegister == idx)) begin
         result = wb_WriteData;
      end
      return result;
   endfunction

   // Operand selection: a load bypasses the fresh read-port data, a stall
   // re-bypasses the already held operands using the held source indices.
   always_comb begin
      nextA = byp(ReadRegister1, ReadData1);
      nextB = byp(ReadRegister2, ReadData2);
      if (stall) begin
         nextA = byp(ex_Rn, ex_A);
         nextB = byp(ex_Rm, ex_B);
      end
   end

   // Pipeline register with priority reset > flush > stall > load. The
   // RUN/HOLD state tracks whether the previous edge was a stall; the held
   // contents are the only visible effect of being in HOLD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         ex_A     <= '0;
         ex_B     <= '0;
         ex_Rn    <= '0;
         ex_Rm    <= '0;
         ex_Rd    <= '0;
         ex_ctrl  <= '0;
         ex_imm   <= '0;
         ex_valid <= 1'b0;
      end else begin
         case (state)
            RUN:     if (stall && !flush) state <= HOLD;
            HOLD:    if (!stall || flush) state <= RUN;
            default: state <= RUN;
         endcase

         if (flush) begin
            ex_A     <= '0;
            ex_B     <= '0;
            ex_Rn    <= '0;
            ex_Rm    <= '0;
            ex_Rd    <= '0;
            ex_ctrl  <= '0;
            ex_imm   <= '0;
            ex_valid <= 1'b0;
         end else if (stall) begin
            ex_A <= nextA;
            ex_B <= nextB;
         end else begin
            ex_A     <= nextA;
            ex_B     <= nextB;
            ex_Rn    <= ReadRegister1;
            ex_Rm    <= ReadRegister2;
            ex_Rd    <= id_Rd;
            ex_imm   <= id_imm;
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : 8'h00;
         end
      end
   end

`ifdef BUBBLE_CNT_EN
   // Counts edges that leave a bubble in EX, from a flush or from loading an
   // invalid decode slot. Stalls hold the slot and are not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_count <= '0;
      end else if ((flush || (!stall && !id_valid)) && (bubble_count != 32'hFFFF_FFFF)) begin
         bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
// ---------------------------------------------------------------------------
// Self-checking bench for id_ex_operand_stage. Directed steps cover reset,
// bypass, XZR, stall coherence, flush-over-stall and duplicate sources, then
// a randomized run is compared against a behavioural model of the EX slot.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

   logic        clk;
   logic        reset;
   logic [63:0] ReadData1, ReadData2;
   logic [4:0]  ReadRegister1, ReadRegister2, id_Rd;
   logic        id_valid;
   logic [7:0]  id_ctrl;
   logic [63:0] id_imm;
   logic        stall, flush;
   logic        wb_RegWrite;
   logic [4:0]  wb_WriteRegister;
   logic [63:0] wb_WriteData;
   logic [63:0] ex_A, ex_B, ex_imm;
   logic [4:0]  ex_Rn, ex_Rm, ex_Rd;
   logic [7:0]  ex_ctrl;
   logic        ex_valid;
`ifdef BUBBLE_CNT_EN
   logic [31:0] bubble_count;
`endif

   int vectors;
   int miscompares;

   // Behavioural picture of what the EX slot should hold.
   logic [63:0] mA, mB, mImm;
   logic [4:0]  mRn, mRm, mRd;
   logic [7:0]  mCtrl;
   logic        mValid;
   longint unsigned mBubbles;

   id_ex_operand_stage dut (
      .clk              (clk),
      .reset            (reset),
      .ReadData1        (ReadData1),
      .ReadData2        (ReadData2),
      .ReadRegister1    (ReadRegister1),
      .ReadRegister2    (ReadRegister2),
      .id_Rd            (id_Rd),
      .id_valid         (id_valid),
      .id_ctrl          (id_ctrl),
      .id_imm           (id_imm),
      .stall            (stall),
      .flush            (flush),
      .wb_RegWrite      (wb_RegWrite),
      .wb_WriteRegister (wb_WriteRegister),
      .wb_WriteData     (wb_WriteData),
      .ex_A             (ex_A),
      .ex_B             (ex_B),
      .ex_Rn            (ex_Rn),
      .ex_Rm            (ex_Rm),
      .ex_Rd            (ex_Rd),
      .ex_ctrl          (ex_ctrl),
      .ex_imm           (ex_imm),
      .ex_valid         (ex_valid)
`ifdef BUBBLE_CNT_EN
      ,
      .bubble_count     (bubble_count)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Value an instruction reading register idx sees this cycle: XZR is zero,
   // a same-cycle write-back wins over the stale register file data.
   function automatic logic [63:0] seenValue(input logic [4:0] idx, input logic [63:0] fileData);
      if (idx == 5'd31) return 64'd0;
      if (wb_RegWrite && (wb_WriteRegister == idx)) return wb_WriteData;
      return fileData;
   endfunction

   task automatic modelReset();
      mA = 0; mB = 0; mImm = 0; mRn = 0; mRm = 0; mRd = 0;
      mCtrl = 0; mValid = 0; mBubbles = 0;
   endtask

   // Advance the model by one edge using the inputs currently applied.
   task automatic modelEdge();
      if (flush) begin
         mA = 0; mB = 0; mImm = 0; mRn = 0; mRm = 0; mRd = 0;
         mCtrl = 0; mValid = 0;
         mBubbles = mBubbles + 1;
      end else if (stall) begin
         mA = seenValue(mRn, mA);
         mB = seenValue(mRm, mB);
      end else begin
         mA = seenValue(ReadRegister1, ReadData1);
         mB = seenValue(ReadRegister2, ReadData2);
         mRn = ReadRegister1; mRm = ReadRegister2; mRd = id_Rd;
         mImm = id_imm; mValid = id_valid;
         mCtrl = id_valid ? id_ctrl : 8'h00;
         if (!id_valid) mBubbles = mBubbles + 1;
      end
      if (mBubbles > 64'hFFFF_FFFF) mBubbles = 64'hFFFF_FFFF;
   endtask

   task automatic compare(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkOutput(input string step);
      compare({step, ".ex_A"},     ex_A,     mA);
      compare({step, ".ex_B"},     ex_B,     mB);
      compare({step, ".ex_Rn"},    {59'd0, ex_Rn},   {59'd0, mRn});
      compare({step, ".ex_Rm"},    {59'd0, ex_Rm},   {59'd0, mRm});
      compare({step, ".ex_Rd"},    {59'd0, ex_Rd},   {59'd0, mRd});
      compare({step, ".ex_ctrl"},  {56'd0, ex_ctrl}, {56'd0, mCtrl});
      compare({step, ".ex_imm"},   ex_imm,   mImm);
      compare({step, ".ex_valid"}, {63'd0, ex_valid}, {63'd0, mValid});
`ifdef BUBBLE_CNT_EN
      compare({step, ".bubble_count"}, {32'd0, bubble_count}, mBubbles);
`endif
   endtask

   task automatic applyStimulus(input logic [4:0] rr1, input logic [63:0] rd1,
                                input logic [4:0] rr2, input logic [63:0] rd2,
                                input logic [4:0] rd, input logic valid,
                                input logic [7:0] ctrl, input logic [63:0] imm,
                                input logic stl, input logic fls,
                                input logic wbWe, input logic [4:0] wbReg,
                                input logic [63:0] wbData);
      ReadRegister1 = rr1; ReadData1 = rd1;
      ReadRegister2 = rr2; ReadData2 = rd2;
      id_Rd = rd; id_valid = valid; id_ctrl = ctrl; id_imm = imm;
      stall = stl; flush = fls;
      wb_RegWrite = wbWe; wb_WriteRegister = wbReg; wb_WriteData = wbData;
   endtask

   // One clock edge: model steps with the applied inputs, DUT sampled 1ns later.
   task automatic clockEdge(input string step);
      modelEdge();
      @(posedge clk);
      #1;
      checkOutput(step);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      applyStimulus(5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
      modelReset();
      @(posedge clk);
      #1;
      checkOutput("reset");
      reset = 1'b0;

      // Load then reset between edges: outputs must clear without a clock.
      applyStimulus(5'd1, 64'h1234, 5'd2, 64'h77, 5'd4, 1'b1, 8'hA5, 64'h10, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
      clockEdge("load1234");
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("asyncReset");
      #1;
      reset = 1'b0;

      // Same-cycle bypass, with and without write enable.
      applyStimulus(5'd5, 64'hAAAA, 5'd6, 64'h6, 5'd9, 1'b1, 8'h81, 64'h1, 1'b0, 1'b0, 1'b1, 5'd5, 64'h5555);
      clockEdge("bypassOn");
      compare("bypassOn.direct", ex_A, 64'h5555);
      applyStimulus(5'd5, 64'hAAAA, 5'd6, 64'h6, 5'd9, 1'b1, 8'h81, 64'h1, 1'b0, 1'b0, 1'b0, 5'd5, 64'h5555);
      clockEdge("bypassOff");
      compare("bypassOff.direct", ex_A, 64'hAAAA);

      // XZR is zero even when written back.
      applyStimulus(5'd1, 64'h11, 5'd31, 64'hDEAD, 5'd2, 1'b1, 8'h42, 64'h2, 1'b0, 1'b0, 1'b1, 5'd31, 64'hBEEF);
      clockEdge("xzr");
      compare("xzr.direct", ex_B, 64'd0);

      // Stall coherence: write-back to r7 in the 2nd stall cycle refreshes ex_A.
      applyStimulus(5'd7, 64'h10, 5'd8, 64'h20, 5'd12, 1'b1, 8'hC3, 64'h33, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
      clockEdge("stallLoad");
      applyStimulus(5'd1, 64'hFF, 5'd2, 64'hEE, 5'd3, 1'b1, 8'h11, 64'h44, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
      clockEdge("stall1");
      applyStimulus(5'd1, 64'hFF, 5'd2, 64'hEE, 5'd3, 1'b1, 8'h11, 64'h44, 1'b1, 1'b0, 1'b1, 5'd7, 64'h99);
      clockEdge("stall2");
      compare("stall2.direct", ex_A, 64'h99);
      applyStimulus(5'd1, 64'hFF, 5'd2, 64'hEE, 5'd3, 1'b1, 8'h11, 64'h44, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
      clockEdge("stall3");
      compare("stall3.ctrl", {56'd0, ex_ctrl}, 64'hC3);
      compare("stall3.rd", {59'd0, ex_Rd}, 64'd12);
      applyStimulus(5'd1, 64'hFF, 5'd2, 64'hEE, 5'd3, 1'b1, 8'h11, 64'h44, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
      clockEdge("resume");

      // Flush beats stall.
      applyStimulus(5'd1, 64'hFF, 5'd2, 64'hEE, 5'd3, 1'b1, 8'h11, 64'h44, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0);
      clockEdge("flushStall");

      // Duplicate sources see the same bypassed value.
      applyStimulus(5'd3, 64'h1, 5'd3, 64'h1, 5'd4, 1'b1, 8'h21, 64'h5, 1'b0, 1'b0, 1'b1, 5'd3, 64'h42);
      clockEdge("dupSrc");
      compare("dupSrc.B", ex_B, 64'h42);

      // Randomized traffic; write-back often targets a live source index.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] r1, r2, wr;
         r1 = 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0: wr = r1;
            1: wr = r2;
            2: wr = mRn;
            default: wr = 5'($urandom_range(0, 31));
         endcase
         applyStimulus(r1, {$urandom, $urandom}, r2, {$urandom, $urandom},
                       5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                       8'($urandom), {$urandom, $urandom},
                       1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)), wr, {$urandom, $urandom});
         clockEdge("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
